mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences one shared ALU, memory port and register file

---
 rtl/mc_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives every datapath strobe, mux select and the immediate-extender format.
module mc_ctrl #(
    parameter int unsigned TO_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       br_taken_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_ifetch_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       rf_we_o,
    output logic [1:0] wd_sel_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic [1:0] alu_ctrl_o,
    output logic [5:0] ext_op_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    localparam logic [5:0] ExtI = 6'b010000;
    localparam logic [5:0] ExtS = 6'b001000;
    localparam logic [5:0] ExtB = 6'b000100;
    localparam logic [5:0] ExtU = 6'b000010;
    localparam logic [5:0] ExtJ = 6'b000001;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluPassB = 2'b11;

    // Last waiting count before the watchdog fires: 2**TO_W-1 waiting cycles in total.
    localparam logic [TO_W-1:0] WdLast = {{(TO_W-1){1'b1}}, 1'b0};

    state_e          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    logic is_r, is_imm, is_load, is_store, is_br, is_lui, is_auipc, is_jal, is_jalr, is_legal;
    logic [5:0] ext_dec;

    // funct3 is consumed by the datapath ALU decoder, not by the sequencer.
    logic unused_funct3;
    assign unused_funct3 = ^funct3_i;

    always_comb begin
        is_r     = (opcode_i == OpR);
        is_imm   = (opcode_i == OpImm);
        is_load  = (opcode_i == OpLoad);
        is_store = (opcode_i == OpStore);
        is_br    = (opcode_i == OpBr);
        is_lui   = (opcode_i == OpLui);
        is_auipc = (opcode_i == OpAuipc);
        is_jal   = (opcode_i == OpJal);
        is_jalr  = (opcode_i == OpJalr);
        is_legal = is_r | is_imm | is_load | is_store | is_br | is_lui | is_auipc | is_jal
                 | is_jalr;
    end

    always_comb begin
        ext_dec = 6'b000000;
        if (is_imm || is_load || is_jalr) begin
            ext_dec = ExtI;
        end else if (is_store) begin
            ext_dec = ExtS;
        end else if (is_br) begin
            ext_dec = ExtB;
        end else if (is_lui || is_auipc) begin
            ext_dec = ExtU;
        end else if (is_jal) begin
            ext_dec = ExtJ;
        end
    end

    always_comb begin
        state_d      = state_q;
        wd_d         = '0;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_ifetch_o = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 2'b00;
        rf_we_o      = 1'b0;
        wd_sel_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 1'b0;
        alu_ctrl_o   = AluAdd;
        ext_op_o     = 6'b000000;

        // ALU operand/function selects stay valid from EXEC through WB so alu_out is stable.
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            if (is_r) begin
                alu_ctrl_o = AluFunct;
            end else if (is_imm) begin
                alu_ctrl_o  = AluFunct;
                alu_src_b_o = 1'b1;
            end else if (is_lui) begin
                alu_ctrl_o  = AluPassB;
                alu_src_b_o = 1'b1;
            end else if (is_auipc) begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 1'b1;
            end else if (is_load || is_store || is_jalr) begin
                alu_src_b_o = 1'b1;
            end else if (is_br) begin
                alu_ctrl_o = AluSub;
            end
        end

        if (state_q == StDecode || state_q == StExec || state_q == StMem || state_q == StWb) begin
            ext_op_o = ext_dec;
        end

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                mem_req_o    = 1'b1;
                mem_ifetch_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = StDecode;
                end else if (wd_q == WdLast) begin
                    bus_err_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            StDecode: begin
                if (is_legal) begin
                    state_d = StExec;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end
            end
            StExec: begin
                if (is_br) begin
                    pc_we_o  = br_taken_i;
                    pc_src_o = 2'b10;
                    state_d  = StFetch;
                end else if (is_jal) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = 2'b10;
                    state_d  = StWb;
                end else if (is_jalr) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = 2'b01;
                    state_d  = StWb;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                mem_req_o = 1'b1;
                mem_we_o  = is_store;
                if (mem_ready_i) begin
                    state_d = is_load ? StWb : StFetch;
                end else if (wd_q == WdLast) begin
                    bus_err_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            StWb: begin
                rf_we_o = 1'b1;
                if (is_load) begin
                    wd_sel_o = 2'b01;
                end else if (is_jal || is_jalr) begin
                    wd_sel_o = 2'b10;
                end
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            wd_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle vectors with expected outputs queued as a scoreboard,
// plus hand sequences for reset-mid-request and the memory watchdog.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       ifc;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic       rfwe;
        logic [1:0] wd;
        logic       a;
        logic       b;
        logic [1:0] alu;
        logic [5:0] ext;
        logic       ill;
        logic       berr;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       br;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] ADDI  = 7'h13;
    localparam logic [6:0] LW    = 7'h03;
    localparam logic [6:0] SW    = 7'h23;
    localparam logic [6:0] BEQ   = 7'h63;
    localparam logic [6:0] JAL   = 7'h6F;
    localparam logic [6:0] JALR  = 7'h67;
    localparam logic [6:0] RTYP  = 7'h33;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;
    localparam logic [6:0] BAD   = 7'h7F;

    localparam logic [5:0] EI = 6'b010000;
    localparam logic [5:0] ES = 6'b001000;
    localparam logic [5:0] EB = 6'b000100;
    localparam logic [5:0] EU = 6'b000010;
    localparam logic [5:0] EJ = 6'b000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, br, rdy;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req, mem_we, mem_ifetch, ir_we, pc_we, rf_we, a_sel, b_sel, illegal, bus_err;
    logic [1:0] pc_src, wd_sel, alu_ctrl;
    logic [5:0] ext_op;
    logic [2:0] state;

    logic       rstn_w, rdy_w;
    logic       mem_req_w, mem_we_w, mem_ifetch_w, ir_we_w, pc_we_w, rf_we_w, a_w, b_w;
    logic       illegal_w, bus_err_w;
    logic [1:0] pc_src_w, wd_sel_w, alu_ctrl_w;
    logic [5:0] ext_op_w;
    logic [2:0] state_w;

    mc_ctrl #(.TO_W(8)) dut (
        .clk_i(clk), .rst_ni(rstn), .opcode_i(opcode), .funct3_i(funct3),
        .br_taken_i(br), .mem_ready_i(rdy), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_ifetch_o(mem_ifetch), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
        .rf_we_o(rf_we), .wd_sel_o(wd_sel), .alu_src_a_o(a_sel), .alu_src_b_o(b_sel),
        .alu_ctrl_o(alu_ctrl), .ext_op_o(ext_op), .illegal_o(illegal), .bus_err_o(bus_err),
        .state_o(state)
    );

    mc_ctrl #(.TO_W(3)) dut_w (
        .clk_i(clk), .rst_ni(rstn_w), .opcode_i(ADDI), .funct3_i(3'b000),
        .br_taken_i(1'b0), .mem_ready_i(rdy_w), .mem_req_o(mem_req_w), .mem_we_o(mem_we_w),
        .mem_ifetch_o(mem_ifetch_w), .ir_we_o(ir_we_w), .pc_we_o(pc_we_w), .pc_src_o(pc_src_w),
        .rf_we_o(rf_we_w), .wd_sel_o(wd_sel_w), .alu_src_a_o(a_w), .alu_src_b_o(b_w),
        .alu_ctrl_o(alu_ctrl_w), .ext_op_o(ext_op_w), .illegal_o(illegal_w),
        .bus_err_o(bus_err_w), .state_o(state_w)
    );

    outs_t act, act_w;
    assign act = {state, mem_req, mem_we, mem_ifetch, ir_we, pc_we, pc_src, rf_we, wd_sel,
                  a_sel, b_sel, alu_ctrl, ext_op, illegal, bus_err};
    assign act_w = {state_w, mem_req_w, mem_we_w, mem_ifetch_w, ir_we_w, pc_we_w, pc_src_w,
                    rf_we_w, wd_sel_w, a_w, b_w, alu_ctrl_w, ext_op_w, illegal_w, bus_err_w};

    int    n_cmp = 0;
    int    n_err = 0;
    outs_t exp_q[$];
    vec_t  vecs[$];

    function automatic outs_t mk(input logic [2:0] st, input logic req, input logic we,
                                 input logic ifc, input logic irwe, input logic pcwe,
                                 input logic [1:0] pcsrc, input logic rfwe, input logic [1:0] wd,
                                 input logic a, input logic b, input logic [1:0] alu,
                                 input logic [5:0] ext);
        outs_t o;
        o = '{st: st, req: req, we: we, ifc: ifc, irwe: irwe, pcwe: pcwe, pcsrc: pcsrc,
              rfwe: rfwe, wd: wd, a: a, b: b, alu: alu, ext: ext, ill: 1'b0, berr: 1'b0};
        return o;
    endfunction

    task automatic add(input logic [6:0] op, input logic b_i, input logic r_i, input outs_t e);
        vec_t v;
        v.op  = op;
        v.br  = b_i;
        v.rdy = r_i;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input outs_t got);
        outs_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", name, got, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        outs_t zero, fr, fw, t;
        zero = mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0);
        fr   = mk(3'd1, 1, 0, 1, 1, 1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0);
        fw   = mk(3'd1, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0);

        // addi: IDLE, FETCH, DECODE, EXEC, WB
        add(ADDI, 0, 1, zero);
        add(ADDI, 0, 1, fr);
        add(ADDI, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EI));
        add(ADDI, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10, EI));
        add(ADDI, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 2'b10, EI));
        // lw with three wait cycles in MEM
        add(LW, 0, 1, fr);
        add(LW, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EI));
        add(LW, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b00, EI));
        for (int k = 0; k < 3; k++) begin
            add(LW, 0, 0, mk(3'd4, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b00, EI));
        end
        add(LW, 0, 1, mk(3'd4, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b00, EI));
        add(LW, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 1, 2'b00, EI));
        // beq taken, then not taken
        add(BEQ, 1, 1, fr);
        add(BEQ, 1, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EB));
        add(BEQ, 1, 1, mk(3'd3, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 0, 2'b01, EB));
        add(BEQ, 0, 1, fr);
        add(BEQ, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EB));
        add(BEQ, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b10, 0, 2'b00, 0, 0, 2'b01, EB));
        // jal
        add(JAL, 0, 1, fr);
        add(JAL, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EJ));
        add(JAL, 0, 1, mk(3'd3, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 0, 2'b00, EJ));
        add(JAL, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 0, 2'b00, EJ));
        // sw, zero-wait
        add(SW, 0, 1, fr);
        add(SW, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, ES));
        add(SW, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b00, ES));
        add(SW, 0, 1, mk(3'd4, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b00, ES));
        // R-type
        add(RTYP, 0, 1, fr);
        add(RTYP, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0));
        add(RTYP, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 6'd0));
        add(RTYP, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 2'b10, 6'd0));
        // lui
        add(LUI, 0, 1, fr);
        add(LUI, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EU));
        add(LUI, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b11, EU));
        add(LUI, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 2'b11, EU));
        // auipc
        add(AUIPC, 0, 1, fr);
        add(AUIPC, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EU));
        add(AUIPC, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 2'b00, EU));
        add(AUIPC, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 1, 2'b00, EU));
        // jalr
        add(JALR, 0, 1, fr);
        add(JALR, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EI));
        add(JALR, 0, 1, mk(3'd3, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 1, 2'b00, EI));
        add(JALR, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 1, 2'b00, EI));
        // one FETCH wait cycle; mem_ready outside a request must not matter
        add(ADDI, 0, 0, fw);
        add(ADDI, 0, 1, fr);
        add(ADDI, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, EI));
        add(ADDI, 0, 1, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10, EI));
        add(ADDI, 0, 1, mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 2'b10, EI));
        // unsupported opcode traps after DECODE and stays there
        add(BAD, 0, 1, fr);
        add(BAD, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0));
        t = mk(3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0);
        t.ill = 1'b1;
        for (int k = 0; k < 3; k++) add(BAD, 0, 1, t);

        rstn   = 1'b0;
        rstn_w = 1'b0;
        rdy_w  = 1'b0;
        opcode = ADDI;
        funct3 = 3'b000;
        br     = 1'b0;
        rdy    = 1'b1;
        #1;
        exp_q.push_back(zero);
        check("reset_state", act);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            opcode = vecs[i].op;
            br     = vecs[i].br;
            rdy    = vecs[i].rdy;
            exp_q.push_back(vecs[i].exp);
            #1;
            check($sformatf("vec[%0d]", i), act);
        end

        // Reset pulse clears the sticky trap and restarts from IDLE.
        @(negedge clk);
        rstn = 1'b0;
        #1;
        exp_q.push_back(zero);
        check("trap_reset_async", act);
        @(negedge clk);
        opcode = ADDI;
        rdy    = 1'b0;
        rstn   = 1'b1;
        #1;
        exp_q.push_back(zero);
        check("trap_reset_idle", act);
        @(negedge clk);
        #1;
        exp_q.push_back(fw);
        check("fetch_wait", act);
        // Reset asserted mid-request drops mem_req without a clock edge.
        #2;
        rstn = 1'b0;
        #1;
        exp_q.push_back(zero);
        check("reset_mid_fetch", act);
        @(negedge clk);
        rstn = 1'b1;

        // Watchdog with TO_W=3: seven waiting FETCH cycles, then TRAP with bus_err.
        rstn_w = 1'b1;
        #1;
        exp_q.push_back(zero);
        check("wd_idle", act_w);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            exp_q.push_back(fw);
            check($sformatf("wd_fetch[%0d]", k), act_w);
        end
        t = mk(3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 6'd0);
        t.berr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rdy_w = 1'b1;
            #1;
            exp_q.push_back(t);
            check($sformatf("wd_trap[%0d]", k), act_w);
        end
        rstn_w = 1'b0;
        #1;
        exp_q.push_back(zero);
        check("wd_reset", act_w);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
